// File: rtl/axis_arbiter_pkg.sv
// Shared types and helpers for the weighted AXI-Stream arbiter.
// The grant state value doubles as the output_source encoding.
package axis_arbiter_pkg;

   localparam int NUM_PORTS = 3;

   typedef enum logic [1:0] {
      GRANT_0 = 2'd0,
      GRANT_1 = 2'd1,
      GRANT_2 = 2'd2
   } grant_e;

   // First port after cur in rotation (cur itself considered last) whose mask bit is set.
   function automatic grant_e next_port(input grant_e cur, input logic [NUM_PORTS-1:0] mask);
      grant_e     res;
      logic [1:0] idx;
      res = cur;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         idx = 2'((int'(cur) + i) % NUM_PORTS);
         if (mask[idx]) res = grant_e'(idx);
      end
      return res;
   endfunction

   // First masked port scanning from port 0 upward.
   function automatic grant_e first_port(input logic [NUM_PORTS-1:0] mask);
      return next_port(GRANT_2, mask);
   endfunction

endpackage

// File: rtl/axis_weighted_arbiter_if.sv
// Three AXIS slave inputs and one AXIS master output of the weighted arbiter.
// master = arbiter side, slave = upstream sources / downstream sink side.
interface axis_weighted_arbiter_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  input_0_valid;
   logic                  input_0_ready;
   logic [DATA_WIDTH-1:0] input_0_data;
   logic                  input_1_valid;
   logic                  input_1_ready;
   logic [DATA_WIDTH-1:0] input_1_data;
   logic                  input_2_valid;
   logic                  input_2_ready;
   logic [DATA_WIDTH-1:0] input_2_data;
   logic                  output_valid;
   logic                  output_ready;
   logic [DATA_WIDTH-1:0] output_data;
   logic [1:0]            output_source;
   logic                  output_last;

   modport master (
      input  input_0_valid, input_0_data, input_1_valid, input_1_data,
      input  input_2_valid, input_2_data, output_ready,
      output input_0_ready, input_1_ready, input_2_ready,
      output output_valid, output_data, output_source, output_last
   );

   modport slave (
      output input_0_valid, input_0_data, input_1_valid, input_1_data,
      output input_2_valid, input_2_data, output_ready,
      input  input_0_ready, input_1_ready, input_2_ready,
      input  output_valid, output_data, output_source, output_last
   );
endinterface

// File: rtl/axis_arbiter_burst_counter.sv
// Burst transfer counter; terminal flags the last transfer of the current burst.
// Wraps to zero on an enabled terminal beat.
module axis_arbiter_burst_counter #(
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   clear,
   input  logic [COUNT_WIDTH-1:0] limit,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   terminal
);

   assign terminal = (count == limit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= terminal ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/axis_weighted_arbiter.sv
// Weighted round-robin AXIS arbiter: zero-latency pass-through of the granted
// input, bursts of WEIGHT_k transfers per port, idle ports skipped at burst start.
module axis_weighted_arbiter
   import axis_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int WEIGHT_0    = 17,
   parameter int WEIGHT_1    = 17,
   parameter int WEIGHT_2    = 1,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   axis_weighted_arbiter_if.master bus
);

   localparam int WEIGHT [NUM_PORTS] = '{WEIGHT_0, WEIGHT_1, WEIGHT_2};
   localparam int WMAX = (1 << COUNT_WIDTH) - 1;
   localparam logic [NUM_PORTS-1:0] NZ_MASK = {WEIGHT_2 != 0, WEIGHT_1 != 0, WEIGHT_0 != 0};
   localparam grant_e FIRST_PORT = first_port(NZ_MASK);

   generate
      if (WEIGHT_0 < 0 || WEIGHT_0 > WMAX || WEIGHT_1 < 0 || WEIGHT_1 > WMAX ||
          WEIGHT_2 < 0 || WEIGHT_2 > WMAX) begin : g_bad_range
         $error("axis_weighted_arbiter: weight outside 0..2^COUNT_WIDTH-1");
      end
      if (NZ_MASK == '0) begin : g_all_zero
         $error("axis_weighted_arbiter: at least one weight must be nonzero");
      end
   endgenerate

   grant_e                               state, state_nxt;
   logic [NUM_PORTS-1:0]                 in_valid, in_ready, req_mask;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] in_data;
   logic [NUM_PORTS-1:0][COUNT_WIDTH-1:0] limit_tbl;
   logic [COUNT_WIDTH-1:0]               cnt;
   logic                                 active, sel_valid, xfer, terminal;

   assign in_valid = {bus.input_2_valid, bus.input_1_valid, bus.input_0_valid};
   assign in_data  = {bus.input_2_data,  bus.input_1_data,  bus.input_0_data};
   assign bus.input_0_ready = in_ready[0];
   assign bus.input_1_ready = in_ready[1];
   assign bus.input_2_ready = in_ready[2];

   // Weight-0 ports wrap to all-ones here but are never granted.
   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_limit
      assign limit_tbl[k] = COUNT_WIDTH'(WEIGHT[k] - 1);
   end

   assign active    = rst & ~clear;
   assign sel_valid = in_valid[state];
   assign req_mask  = in_valid & NZ_MASK;
   assign xfer      = bus.output_valid & bus.output_ready;

   axis_arbiter_burst_counter #(
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_burst_counter (
      .clk      (clk),
      .rst      (rst),
      .enable   (xfer),
      .clear    (clear),
      .limit    (limit_tbl[state]),
      .count    (cnt),
      .terminal (terminal)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FIRST_PORT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt         = state;
      in_ready          = '0;
      bus.output_valid  = active & sel_valid;
      bus.output_data   = in_data[state];
      bus.output_source = state;
      bus.output_last   = active & sel_valid & terminal;
      for (int k = 0; k < NUM_PORTS; k++)
         in_ready[k] = active & bus.output_ready & (int'(state) == k);

      if (clear) begin
         state_nxt = FIRST_PORT;
      end else if (xfer && terminal) begin
         // Hand over to the next requesting port so a lone active source streams
         // without bubbles; with nobody requesting, rotate plainly.
         state_nxt = (|req_mask) ? next_port(state, req_mask) : next_port(state, NZ_MASK);
      end else if (cnt == '0 && !sel_valid) begin
         state_nxt = next_port(state, req_mask);
      end
   end

`ifndef SYNTHESIS
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(in_ready));
   a_src_stable: assert property (@(posedge clk) disable iff (!rst)
      (bus.output_valid && !bus.output_ready && !clear) |=> bus.output_source == $past(bus.output_source));
   a_burst_locked: assert property (@(posedge clk) disable iff (!rst)
      (cnt != '0 && !clear && !(xfer && terminal)) |=> state == $past(state));
`endif

endmodule
